// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types for the iterative multiply/divide unit.
//   md_op_t    : operation select (MUL / DIV)
//   md_state_t : sequencer state encoding
package muldiv_pkg;

   typedef enum logic {
      MD_MUL = 1'b0,
      MD_DIV = 1'b1
   } md_op_t;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2
   } md_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative WIDTH-bit multiply / divide with signed and unsigned modes.
//   clk, rst        : clock, asynchronous active-high reset
//   suspend         : freeze all state (start ignored)
//   flush           : synchronous abort to idle; beats suspend and start
//   start, op       : request (accepted in idle only), MUL=0 / DIV=1
//   is_signed       : two's-complement operands
//   operand_a/b     : multiplicand/dividend, multiplier/divisor
//   busy            : operation in flight
//   done            : one-cycle result-valid pulse (stretched by suspend)
//   result_lo/hi    : MUL product low/high half; DIV quotient/remainder
//   div_by_zero     : divisor was zero on the last completed operation
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             suspend,
   input  logic             flush,
   input  logic             start,
   input  md_op_t           op,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             div_by_zero
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   md_state_t          state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   md_op_t             op_q, op_d;
   logic               neg_res_q, neg_res_d;   // product / quotient sign
   logic               neg_rem_q, neg_rem_d;   // remainder sign (dividend sign)
   logic               dbz_q, dbz_d;           // pending divide-by-zero
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   res_lo_q, res_lo_d;
   logic [WIDTH-1:0]   res_hi_q, res_hi_d;
   logic               div_zero_q, div_zero_d;

   // Operand magnitudes
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign a_neg = is_signed & operand_a[WIDTH-1];
   assign b_neg = is_signed & operand_b[WIDTH-1];
   assign a_mag = a_neg ? -operand_a : operand_a;
   assign b_mag = b_neg ? -operand_b : operand_b;

   // Accumulator halves: MUL {partial product, multiplier}; DIV {remainder, dividend/quotient}
   logic [WIDTH-1:0]   acc_hi, acc_lo;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift, div_diff;
   logic               div_ok;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   assign acc_hi    = acc_q[2*WIDTH-1:WIDTH];
   assign acc_lo    = acc_q[WIDTH-1:0];
   assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_q[0] ? b_q : '0)};
   assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
   // Remainder stays below the divisor, so bit WIDTH of the difference is a pure borrow.
   assign div_diff  = div_shift - {1'b0, b_q};
   assign div_ok    = ~div_diff[WIDTH];
   assign div_rem   = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
   assign prod_fix  = neg_res_q ? -acc_q : acc_q;
   assign quot_fix  = neg_res_q ? -acc_lo : acc_lo;
   assign rem_fix   = neg_rem_q ? -acc_hi : acc_hi;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      dbz_d      = dbz_q;
      b_d        = b_q;
      acc_d      = acc_q;
      done_d     = done_q;
      res_lo_d   = res_lo_q;
      res_hi_d   = res_hi_q;
      div_zero_d = div_zero_q;

      if (flush) begin
         state_d = MD_IDLE;
         done_d  = 1'b0;
      end else if (!suspend) begin
         done_d = 1'b0;
         unique case (state_q)
            MD_IDLE: begin
               if (start) begin
                  op_d      = op;
                  cnt_d     = '0;
                  neg_res_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  b_d       = b_mag;
                  dbz_d     = (op == MD_DIV) && (operand_b == '0);
                  if ((op == MD_DIV) && (operand_b == '0)) begin
                     // Keep the raw dividend: it is returned unchanged as the remainder.
                     acc_d   = {{WIDTH{1'b0}}, operand_a};
                     state_d = MD_FIX;
                  end else begin
                     acc_d   = {{WIDTH{1'b0}}, a_mag};
                     state_d = MD_CALC;
                  end
               end
            end
            MD_CALC: begin
               cnt_d = cnt_q + CW'(1);
               if (op_q == MD_MUL) begin
                  acc_d = {mul_sum, acc_lo[WIDTH-1:1]};
               end else begin
                  acc_d = {div_rem, acc_lo[WIDTH-2:0], div_ok};
               end
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_d = MD_FIX;
               end
            end
            MD_FIX: begin
               if (dbz_q) begin
                  res_lo_d = '1;
                  res_hi_d = acc_lo;
               end else if (op_q == MD_MUL) begin
                  res_lo_d = prod_fix[WIDTH-1:0];
                  res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
               end else begin
                  // MIN / -1 falls out naturally: magnitude MIN negated is MIN again.
                  res_lo_d = quot_fix;
                  res_hi_d = rem_fix;
               end
               div_zero_d = dbz_q;
               done_d     = 1'b1;
               state_d    = MD_IDLE;
            end
            default: state_d = MD_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= MD_IDLE;
         cnt_q      <= '0;
         op_q       <= MD_MUL;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         dbz_q      <= 1'b0;
         b_q        <= '0;
         acc_q      <= '0;
         done_q     <= 1'b0;
         res_lo_q   <= '0;
         res_hi_q   <= '0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
         dbz_q      <= dbz_d;
         b_q        <= b_d;
         acc_q      <= acc_d;
         done_q     <= done_d;
         res_lo_q   <= res_lo_d;
         res_hi_q   <= res_hi_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign busy        = (state_q != MD_IDLE);
   assign done        = done_q;
   assign result_lo   = res_lo_q;
   assign result_hi   = res_hi_q;
   assign div_by_zero = div_zero_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit that succeeds the fixed 16-bit MUL/DIV sequencer inside the execute stage. It provides:
- WIDTH-generic operands, a full 2×WIDTH product and signed/unsigned modes;
- quotient and remainder from one divide, with defined divide-by-zero and overflow results;
- an explicit start/busy/done handshake, plus suspend (freeze) and flush (abort).

The execute stage instantiates it beside the single-cycle ALU and stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, 16: operand width in bits; legal range 4–32.

Ports. One clock; reset is asynchronous and active-high.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous active-high reset.
- `suspend` in 1: freezes all state; `start` is ignored.
- `flush` in 1: synchronous abort to IDLE; takes priority over `suspend` and `start`.
- `start` in 1: request; accepted only in IDLE.
- `op` in 1: 0 = MUL, 1 = DIV (package `md_op_t`).
- `is_signed` in 1: two's-complement operands when 1.
- `operand_a` in WIDTH: multiplicand or dividend.
- `operand_b` in WIDTH: multiplier or divisor.
- `busy` out 1: high from the accepting edge until the edge that raises `done`.
- `done` out 1: single-cycle (non-suspended) pulse; results are valid in that cycle.
- `result_lo` out WIDTH: MUL = product[WIDTH-1:0]; DIV = quotient.
- `result_hi` out WIDTH: MUL = product[2·WIDTH-1:WIDTH]; DIV = remainder.
- `div_by_zero` out 1: valid with `done`; held until the next `done`.

## Operation
- States: IDLE, CALC, FIX.
- **IDLE**, with `start=1`, no `flush`, no `suspend`:
  - Latch `op` and `is_signed`.
  - Latch operand magnitudes (negate negative operands when signed) and the result sign bits.
  - Clear the iteration counter; go to CALC; set `busy=1`.
- **DIV with `operand_b==0`** (short-circuit): go directly to FIX; no iterations.
- **CALC**, one iteration per edge, counter 0..WIDTH-1:
  - MUL: shift-add on the unsigned magnitude into a 2·WIDTH accumulator.
  - DIV: restoring shift-subtract; one quotient bit per cycle, MSB first.
  - After iteration WIDTH-1, go to FIX.
- **FIX**: apply sign correction, load `result_lo`/`result_hi`/`div_by_zero`, pulse `done`, drop `busy`, return to IDLE.
- **Signed results**:
  - Product is negated when the operand signs differ.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- **Divide by zero**: `result_lo` = all ones, `result_hi` = `operand_a` unchanged, `div_by_zero=1`. Applies in both signed and unsigned mode.
- **Signed overflow** (MIN / -1): `result_lo` = MIN, `result_hi` = 0, `div_by_zero=0`, normal latency.
- **Result hold**: result registers change only in FIX. They hold through flush and suspend.
- **Suspend**:
  - All registers hold, including `done` (the pulse is stretched).
  - The pulse ends on the first non-suspended edge.
- **Flush**:
  - At the next edge: go to IDLE, clear `busy` and `done`.
  - No result update and no `done` for the aborted operation.
- **`start` while busy**: ignored; no queueing.

## Timing
- **Reset values**: IDLE, `busy=0`, `done=0`, `result_lo=0`, `result_hi=0`, `div_by_zero=0`, counter=0, accumulators=0.
- **Normal latency**: accepting edge E0, CALC edges E1..E_WIDTH, FIX/`done` edge E_WIDTH+1.
  - `done` is high in the cycle after E_WIDTH+1.
  - WIDTH=16 → 17 edges; suspended edges add one each.
- **Divide-by-zero latency**: `done` follows edge E1 (FIX entered at E0).
- **Back-to-back**: `start` may be asserted in the cycle where `done=1` (state is IDLE); it is accepted at that edge.
- **Operand sampling**: operands, `op` and `is_signed` are sampled only at the accepting edge. Later changes are ignored.
- **Reset mid-operation**: outputs clear immediately (asynchronous), with no `done`.
- **Simultaneous controls**: `flush` beats `suspend` beats `start`.

## Structure
- **Package `muldiv_pkg`**:
  - `md_op_t` (MD_MUL=1'b0, MD_DIV=1'b1).
  - `md_state_t` (MD_IDLE, MD_CALC, MD_FIX; 2 bits).
- **Counter width**: $clog2(WIDTH)+1.
- **Single module, no sub-module.** Sign handling and the iteration datapath are small enough to stay inline.
- **Execute-stage use**:
  - Tie `start` to "MUL/DIV opcode and not busy".
  - Use `busy` for the stall.

## Test plan
1. Unsigned MUL (WIDTH=16): 0x1234 × 0x0010 → `result_lo`=0x2340, `result_hi`=0x0001, `done` exactly 17 edges after the accepting edge, `busy` high for 17 cycles.
2. Signed MUL and DIV:
   - −3 × 5 → `result_lo`=0xFFF1, `result_hi`=0xFFFF.
   - −7 / 2 (0xFFF9 / 0x0002) → `result_lo`=0xFFFD, `result_hi`=0xFFFF.
3. Divide by zero: 0x00AB / 0 unsigned → `result_lo`=0xFFFF, `result_hi`=0x00AB, `div_by_zero`=1, `done` one edge after the accepting edge. Then 0x0064 / 7 → 0x000E, rem 0x0002, `div_by_zero`=0.
4. Signed overflow: 0x8000 / 0xFFFF → `result_lo`=0x8000, `result_hi`=0x0000, `div_by_zero`=0, 17-edge latency.
5. Suspend:
   - 300 × 300 unsigned with `suspend` high for 5 cycles starting at cycle 8 → `done` at edge 22, `result_lo`=0x5F90, `result_hi`=0x0001.
   - Suspend asserted during `done` → `done` stays high until released.
6. Control hazards:
   - `flush` at cycle 6 → `busy`=0 next edge, no `done`, results keep their previous values.
   - `rst` pulse mid-DIV → all outputs 0 immediately.
   - New `start` in the `done` cycle → accepted, second result correct.
